// File: rtl/console_pkg.sv
// Shared definitions for the console bus blocks: config register map,
// control/status bit positions, sprite DMA state encoding and bus polarity.
package console_pkg;

    localparam logic [1:0] REG_SRC_HI = 2'd0;
    localparam logic [1:0] REG_SRC_LO = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_ARM_BIT    = 0;
    localparam int CTRL_REPEAT_BIT = 1;
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;

    // Sprite bus and config port share the same direction encoding.
    localparam logic SPR_RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_READ    = 2'd2,
        ST_WRITE   = 2'd3
    } dma_state_t;

endpackage

// File: rtl/sprite_dma_cfg_regs.sv
// Sprite DMA config register file: source address, CTRL, sticky DONE
// and the registered CPU read port.
module cfg_regs
    import console_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_cs,
    input  logic        cfg_rw,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_di,
    output logic [7:0]  cfg_dout,
    input  logic        busy,
    input  logic        set_done,
    input  logic        clr_arm,
    output logic [15:0] src_addr,
    output logic        arm,
    output logic        rpt
);

    logic [7:0] src_hi;
    logic [7:0] src_lo;
    logic       done;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] rd_data;

    assign wr_en    = cfg_cs && (cfg_rw == SPR_RW_WRITE);
    assign rd_en    = cfg_cs && (cfg_rw != SPR_RW_WRITE);
    assign src_addr = {src_hi, src_lo};

    always_comb begin
        rd_data = '0;
        case (cfg_addr)
            REG_SRC_HI: rd_data = src_hi;
            REG_SRC_LO: rd_data = src_lo;
            REG_CTRL: begin
                rd_data[CTRL_ARM_BIT]    = arm;
                rd_data[CTRL_REPEAT_BIT] = rpt;
            end
            REG_STATUS: begin
                rd_data[STAT_BUSY_BIT] = busy;
                rd_data[STAT_DONE_BIT] = done;
            end
            default: ;
        endcase
    end

    // Hardware set of DONE and clear of ARM are applied after the CPU write,
    // so completion wins over a coincident software write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_hi   <= '0;
            src_lo   <= '0;
            arm      <= 1'b0;
            rpt      <= 1'b0;
            done     <= 1'b0;
            cfg_dout <= '0;
        end else begin
            if (wr_en) begin
                case (cfg_addr)
                    REG_SRC_HI: src_hi <= cfg_di;
                    REG_SRC_LO: src_lo <= cfg_di;
                    REG_CTRL: begin
                        arm <= cfg_di[CTRL_ARM_BIT];
                        rpt <= cfg_di[CTRL_REPEAT_BIT];
                    end
                    REG_STATUS: if (cfg_di[STAT_DONE_BIT]) done <= 1'b0;
                    default: ;
                endcase
            end
            if (clr_arm)  arm  <= 1'b0;
            if (set_done) done <= 1'b1;
            if (rd_en)    cfg_dout <= rd_data;
        end
    end

endmodule

// File: rtl/sprite_dma.sv
// Sprite DMA engine: on an armed vsync rising edge copies DEST_BYTES bytes
// from main memory into sprite RAM, one read/write pair per byte.
module sprite_dma
    import console_pkg::*;
#(
    parameter int DEST_BYTES = 10,
    parameter int SRC_AW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_cs,
    input  logic              cfg_rw,
    input  logic [1:0]        cfg_addr,
    input  logic [7:0]        cfg_di,
    output logic [7:0]        cfg_dout,
    input  logic              vsync,
    output logic              mem_req,
    output logic [SRC_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              spr_cs,
    output logic              spr_rw,
    output logic [3:0]        spr_addr,
    output logic [7:0]        spr_do,
    output logic              busy,
    output logic              done_irq
);

    dma_state_t        state;
    dma_state_t        state_nx;
    logic              vsync_q;
    logic              vs_rise;
    logic [SRC_AW-1:0] cur_addr;
    logic [3:0]        idx;
    logic [7:0]        byte_q;
    logic              last_byte;
    logic              arm;
    logic              rpt;
    logic              clr_arm;
    logic [15:0]       src_addr;

    assign vs_rise   = vsync & ~vsync_q;
    assign last_byte = (idx == 4'(DEST_BYTES - 1));

    cfg_regs u_cfg_regs (
        .clk      (clk),
        .reset    (reset),
        .cfg_cs   (cfg_cs),
        .cfg_rw   (cfg_rw),
        .cfg_addr (cfg_addr),
        .cfg_di   (cfg_di),
        .cfg_dout (cfg_dout),
        .busy     (busy),
        .set_done (done_irq),
        .clr_arm  (clr_arm),
        .src_addr (src_addr),
        .arm      (arm),
        .rpt      (rpt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // A disarmed engine waiting for vsync drops back to IDLE, which is how
    // ARM=0 written during a REPEAT transfer takes effect at completion.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (arm) state_nx = ST_WAIT_VS;
            ST_WAIT_VS: begin
                if (!arm)         state_nx = ST_IDLE;
                else if (vs_rise) state_nx = ST_READ;
            end
            ST_READ:    if (mem_ack) state_nx = ST_WRITE;
            ST_WRITE: begin
                if (last_byte) state_nx = rpt ? ST_WAIT_VS : ST_IDLE;
                else           state_nx = ST_READ;
            end
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        spr_cs   = 1'b0;
        spr_rw   = ~SPR_RW_WRITE;
        busy     = 1'b0;
        done_irq = 1'b0;
        clr_arm  = 1'b0;
        case (state)
            ST_READ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            ST_WRITE: begin
                spr_cs = 1'b1;
                spr_rw = SPR_RW_WRITE;
                busy   = 1'b1;
                if (last_byte) begin
                    done_irq = 1'b1;
                    clr_arm  = ~rpt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q  <= 1'b0;
            cur_addr <= '0;
            idx      <= '0;
            byte_q   <= '0;
        end else begin
            vsync_q <= vsync;
            if (state == ST_WAIT_VS && state_nx == ST_READ) begin
                cur_addr <= SRC_AW'(src_addr);
                idx      <= '0;
            end
            if (state == ST_READ && mem_ack) byte_q <= mem_rdata;
            if (state == ST_WRITE) begin
                cur_addr <= cur_addr + SRC_AW'(1);
                idx      <= idx + 4'd1;
            end
        end
    end

    assign mem_addr = cur_addr;
    assign spr_addr = idx;
    assign spr_do   = byte_q;

endmodule

// File: tb/tb_sprite_dma.sv
// Randomized bench for sprite_dma: a memory responder with random wait states
// and a transfer-level scoreboard of expected reads, sprite writes and latency.
module tb_sprite_dma;

    localparam int DEST_BYTES = 10;
    localparam int SRC_AW     = 16;
    localparam logic [1:0] A_SRC_HI = 2'd0;
    localparam logic [1:0] A_SRC_LO = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_cs, cfg_rw;
    logic [1:0]        cfg_addr;
    logic [7:0]        cfg_di, cfg_dout;
    logic              vsync;
    logic              mem_req, mem_ack;
    logic [SRC_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              spr_cs, spr_rw, busy, done_irq;
    logic [3:0]        spr_addr;
    logic [7:0]        spr_do;

    always #5 clk = ~clk;

    sprite_dma #(.DEST_BYTES(DEST_BYTES), .SRC_AW(SRC_AW)) dut (
        .clk(clk), .reset(reset), .cfg_cs(cfg_cs), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr),
        .cfg_di(cfg_di), .cfg_dout(cfg_dout), .vsync(vsync), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .spr_cs(spr_cs),
        .spr_rw(spr_rw), .spr_addr(spr_addr), .spr_do(spr_do), .busy(busy), .done_irq(done_irq)
    );

    logic [7:0]  mem [0:65535];
    logic [7:0]  spr_ram [0:15];
    logic [15:0] exp_rd [$];
    logic [11:0] exp_wr [$];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0;
    int n_done = 0, exp_done = 0, n_spr = 0;
    int lat_acc = 0, wait_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0h, expected no such event (t=%0t)", name, act, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory responder: ack after w extra request cycles; each byte then costs w+2 cycles.
    initial begin
        int wcnt, w;
        mem_ack = 1'b0; mem_rdata = '0; wcnt = -1;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_ack = 1'b0; wcnt = -1;
            end else if (mem_req) begin
                if (wcnt < 0) begin
                    w = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                    wcnt = w;
                    lat_acc += w + 2;
                end
                if (wcnt == 0) begin
                    mem_ack = 1'b1; mem_rdata = mem[mem_addr]; wcnt = -1;
                end else begin
                    mem_ack = 1'b0; mem_rdata = 8'($urandom); wcnt--;
                end
            end else begin
                mem_ack = ($urandom_range(0, 5) == 0);
                mem_rdata = 8'($urandom);
                wcnt = -1;
            end
        end
    end

    // Cycle-by-cycle compare against the scoreboard.
    logic prev_cs = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_cs = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        end else begin
            if (prev_req && !prev_ack) begin
                check("mem_req_held", mem_req, 1);
                check("mem_addr_stable", mem_addr, prev_addr);
            end
            if (mem_req && mem_ack) begin
                if (exp_rd.size() == 0) fail_now("unexpected_read", mem_addr);
                else check("mem_addr", mem_addr, exp_rd.pop_front());
            end
            if (spr_cs) begin
                n_spr++;
                check("spr_rw", spr_rw, 1);
                check("spr_cs_gap", prev_cs, 0);
                if (exp_wr.size() == 0) fail_now("unexpected_spr_write", {spr_addr, spr_do});
                else check("spr_write", {spr_addr, spr_do}, exp_wr.pop_front());
                spr_ram[spr_addr] = spr_do;
            end
            if (done_irq) begin
                n_done++;
                check("done_with_last_write", {spr_cs, 8'(exp_wr.size())}, {1'b1, 8'd0});
            end
            prev_cs = spr_cs; prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
        end
    end

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_cs = 1'b1; cfg_rw = 1'b1; cfg_addr = a; cfg_di = d;
        tick(1);
        cfg_cs = 1'b0; cfg_rw = 1'b0;
    endtask

    task automatic cfg_read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        cfg_cs = 1'b1; cfg_rw = 1'b0; cfg_addr = a;
        tick(1);
        cfg_cs = 1'b0;
        check(name, cfg_dout, exp);
    endtask

    task automatic set_src(input logic [15:0] s);
        cfg_write(A_SRC_HI, s[15:8]);
        cfg_write(A_SRC_LO, s[7:0]);
    endtask

    task automatic start_transfer(input logic [15:0] src);
        for (int i = 0; i < DEST_BYTES; i++) begin
            logic [15:0] a;
            a = src + 16'(i);
            exp_rd.push_back(a);
            exp_wr.push_back({4'(i), mem[a]});
        end
        exp_done++;
        lat_acc = 0;
        vsync = 1'b1;
        start_cyc = cyc;
        tick(1);
        vsync = 1'b0;
    endtask

    // exp_cyc < 0 means: use the latency accumulated from the chosen wait states.
    task automatic wait_done(input string name, input int exp_cyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 600; n++) begin
            tick(1);
            if (done_irq) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now({name, "_timeout"}, 0);
        else check({name, "_cycles"}, cyc - start_cyc, (exp_cyc < 0) ? lat_acc : exp_cyc);
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n0;
        logic [15:0] rsrc;
        reset = 1'b1; cfg_cs = 1'b0; cfg_rw = 1'b0; cfg_addr = '0; cfg_di = '0; vsync = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) spr_ram[i] = 8'h00;
        for (int i = 0; i < DEST_BYTES; i++) mem[16'h1230 + i] = 8'hA0 + 8'(i);
        mem[16'h0000] = 8'h5A;
        mem[16'h4000] = 8'hC3;

        tick(3);
        check("reset_ctl", {mem_req, spr_cs, spr_rw, busy, done_irq}, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_spr", {spr_addr, spr_do}, 0);
        check("reset_cfg_dout", cfg_dout, 0);
        reset = 1'b0;
        tick(1);
        cfg_read_check("reset_status", A_STATUS, 8'h00);
        cfg_read_check("reset_ctrl", A_CTRL, 8'h00);

        // Zero-wait transfer from 0x1230.
        wait_mode = 0;
        set_src(16'h1230);
        cfg_write(A_CTRL, 8'h01);
        tick(2);
        start_transfer(16'h1230);
        wait_done("t1", 20);
        check("t1_lat_model", lat_acc, 20);
        check("t1_spr3", spr_ram[3], 8'hA3);
        check("t1_spr9", spr_ram[9], 8'hA9);
        cfg_read_check("t1_status", A_STATUS, 8'h02);
        cfg_addr = A_CTRL;
        tick(1);
        check("cfg_dout_hold", cfg_dout, 8'h02);
        cfg_read_check("t1_ctrl_arm_cleared", A_CTRL, 8'h00);
        cfg_read_check("t1_src_lo", A_SRC_LO, 8'h30);
        cfg_write(A_STATUS, 8'h02);
        cfg_read_check("t1_done_cleared", A_STATUS, 8'h00);

        // Read phase of three cycles per byte.
        wait_mode = 2;
        set_src(16'h0100);
        cfg_write(A_CTRL, 8'h01);
        tick(2);
        start_transfer(16'h0100);
        wait_done("t2", 40);
        check("t2_lat_model", lat_acc, 40);

        // Source address wraps past 0xFFFF.
        wait_mode = -1;
        set_src(16'hFFFC);
        cfg_write(A_CTRL, 8'h01);
        tick(2);
        start_transfer(16'hFFFC);
        wait_done("t3", -1);
        check("t3_wrap_byte", spr_ram[4], 8'h5A);

        // REPEAT: three triggered transfers, extra vsync edges while busy ignored.
        cfg_write(A_STATUS, 8'h02);
        set_src(16'h0200);
        cfg_write(A_CTRL, 8'h03);
        n0 = n_spr;
        for (int r = 0; r < 3; r++) begin
            tick(3);
            start_transfer(16'h0200);
            tick(3);
            vsync = 1'b1;
            tick(1);
            vsync = 1'b0;
            if (r == 0) cfg_read_check("t4_status_busy", A_STATUS, 8'h01);
            wait_done("t4", -1);
        end
        tick(30);
        check("t4_write_count", n_spr - n0, 3 * DEST_BYTES);
        cfg_write(A_CTRL, 8'h00);
        tick(2);
        n0 = n_spr;
        vsync = 1'b1; tick(1); vsync = 1'b0;
        tick(40);
        check("t4_disarmed_no_writes", n_spr - n0, 0);

        // SRC rewritten mid-transfer only affects the next transfer.
        wait_mode = 1;
        set_src(16'h2000);
        cfg_write(A_CTRL, 8'h03);
        tick(2);
        start_transfer(16'h2000);
        tick(2);
        set_src(16'h4000);
        wait_done("t5a", -1);
        tick(2);
        start_transfer(16'h4000);
        wait_done("t5b", -1);
        check("t5_new_src_byte0", spr_ram[0], 8'hC3);
        cfg_write(A_CTRL, 8'h00);
        tick(3);

        // ARM write coinciding with a vsync edge waits for the following edge.
        wait_mode = 0;
        set_src(16'h3000);
        cfg_cs = 1'b1; cfg_rw = 1'b1; cfg_addr = A_CTRL; cfg_di = 8'h01; vsync = 1'b1;
        tick(1);
        cfg_cs = 1'b0; cfg_rw = 1'b0;
        tick(2);
        vsync = 1'b0;
        n0 = n_spr;
        tick(5);
        check("t6_no_early_transfer", n_spr - n0, 0);
        start_transfer(16'h3000);
        wait_done("t6", 20);

        // Reset after the 4th sprite write aborts the transfer.
        set_src(16'h0500);
        cfg_write(A_CTRL, 8'h01);
        tick(2);
        start_transfer(16'h0500);
        k = 0;
        for (int n = 0; n < 100 && k < 4; n++) begin
            tick(1);
            if (spr_cs) k++;
        end
        check("t7_reached_4th_write", k, 4);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("t7_rst_ctl", {mem_req, spr_cs, spr_rw, busy, done_irq}, 0);
        check("t7_rst_addr", {mem_addr, spr_addr, spr_do}, 0);
        check("t7_rst_cfg_dout", cfg_dout, 0);
        exp_rd.delete();
        exp_wr.delete();
        exp_done--;
        tick(2);
        reset = 1'b0;
        tick(1);
        n0 = n_spr;
        for (int r = 0; r < 2; r++) begin
            vsync = 1'b1; tick(2); vsync = 1'b0; tick(3);
        end
        tick(30);
        check("t7_no_writes_after_reset", n_spr - n0, 0);
        check("t7_partial_write_kept", spr_ram[3], mem[16'h0503]);
        cfg_read_check("t7_ctrl", A_CTRL, 8'h00);
        cfg_read_check("t7_status", A_STATUS, 8'h00);

        // Randomized transfers.
        wait_mode = -1;
        for (int r = 0; r < 4; r++) begin
            rsrc = 16'($urandom);
            set_src(rsrc);
            cfg_write(A_CTRL, 8'h01);
            tick(int'($urandom_range(2, 6)));
            start_transfer(rsrc);
            wait_done("rand", -1);
        end

        tick(20);
        check("final_wr_queue_empty", exp_wr.size(), 0);
        check("final_rd_queue_empty", exp_rd.size(), 0);
        check("done_irq_count", n_done, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
